dmem_access_ctrl: RTL

Sequences one data-memory access per MEM-stage instruction, driven by the EXE/MEM pipeline register outputs. It handles the load/store request, grant, response handshake to the data-memory bus, generates byte enables and store-data lanes, and sign- or zero-extends load data. It holds the pipeline with stall_o until the access completes. It also reports misaligned or unsupported accesses and bus timeouts as exceptions.

---
 rtl/dmem_access_ctrl_pkg.sv | 31 +++
 rtl/dmem_access_ctrl_lane_fmt.sv | 55 +++++
 rtl/dmem_access_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-memory access controller:
// funct3 load/store codes, exception causes and FSM states.
package dmem_access_ctrl_pkg;

    localparam int GPR_W    = 32;
    localparam int FUNCT3_W = 3;

    localparam logic [FUNCT3_W-1:0] F3_LB  = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_LH  = 3'b001;
    localparam logic [FUNCT3_W-1:0] F3_LW  = 3'b010;
    localparam logic [FUNCT3_W-1:0] F3_LBU = 3'b100;
    localparam logic [FUNCT3_W-1:0] F3_LHU = 3'b101;
    localparam logic [FUNCT3_W-1:0] F3_SB  = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_SH  = 3'b001;
    localparam logic [FUNCT3_W-1:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        EXC_NONE    = 2'b00,
        EXC_LOAD    = 2'b01,
        EXC_STORE   = 2'b10,
        EXC_TIMEOUT = 2'b11
    } exc_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } state_e;

endpackage

// File: rtl/dmem_access_ctrl_lane_fmt.sv
// Combinational lane logic: byte enables, store-data replication, legality
// of the funct3/address pair, and extension of the selected load lane.
module dmem_lane_fmt
    import dmem_access_ctrl_pkg::*;
(
    input  logic [FUNCT3_W-1:0] i_mode,
    input  logic [1:0]          i_addr_lo,
    input  logic                i_is_store,
    input  logic [GPR_W-1:0]    i_wdata,
    input  logic [GPR_W-1:0]    i_rdata,
    output logic [3:0]          o_be,
    output logic [GPR_W-1:0]    o_wdata,
    output logic                o_legal,
    output logic [GPR_W-1:0]    o_load_val
);

    logic        w_supported;
    logic        w_aligned;
    logic [15:0] w_lane;

    assign w_lane = 16'(i_rdata >> {i_addr_lo, 3'b000});

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        o_be       = 4'b0000;
        o_wdata    = i_wdata;
        o_load_val = i_rdata;
        w_aligned  = 1'b0;
        case (i_mode[1:0])
            2'b00: begin
                o_be       = 4'b0001 << i_addr_lo;
                o_wdata    = {4{i_wdata[7:0]}};
                o_load_val = i_mode[2] ? {24'b0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
                w_aligned  = 1'b1;
            end
            2'b01: begin
                o_be       = 4'b0011 << i_addr_lo;
                o_wdata    = {2{i_wdata[15:0]}};
                o_load_val = i_mode[2] ? {16'b0, w_lane} : {{16{w_lane[15]}}, w_lane};
                w_aligned  = ~i_addr_lo[0];
            end
            2'b10: begin
                o_be      = 4'b1111;
                w_aligned = (i_addr_lo == 2'b00);
            end
            default: ;
        endcase
    end

    // Unsupported funct3 codes are reported exactly like misalignment.
    assign w_supported = i_is_store ? (i_mode inside {F3_SB, F3_SH, F3_SW})
                                    : (i_mode inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    assign o_legal     = w_supported & w_aligned;

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer: one req/gnt/rvalid bus transaction
// per load/store, pipeline stall while in flight, exceptions for bad accesses.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                mem_re_i,
    input  logic                mem_we_i,
    input  logic [FUNCT3_W-1:0] mem_mode_i,
    input  logic [GPR_W-1:0]    addr_i,
    input  logic [GPR_W-1:0]    wdata_i,
    output logic                stall_o,
    output logic                done_o,
    output logic [GPR_W-1:0]    load_val_o,
    output logic                exc_o,
    output logic [1:0]          exc_cause_o,
    output logic [GPR_W-1:0]    exc_addr_o,
    output logic                dmem_req_o,
    output logic                dmem_we_o,
    output logic [GPR_W-1:0]    dmem_addr_o,
    output logic [3:0]          dmem_be_o,
    output logic [GPR_W-1:0]    dmem_wdata_o,
    input  logic                dmem_gnt_i,
    input  logic                dmem_rvalid_i,
    input  logic [GPR_W-1:0]    dmem_rdata_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e              r_state;
    logic [GPR_W-1:0]    r_addr;
    logic [FUNCT3_W-1:0] r_mode;
    logic                r_we;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_access;
    logic                w_in_idle;
    logic                w_complete;
    logic                w_timeout;
    logic [FUNCT3_W-1:0] w_fmt_mode;
    logic [1:0]          w_fmt_addr_lo;
    logic                w_fmt_store;
    logic                w_legal;
    logic [3:0]          w_be;
    logic [GPR_W-1:0]    w_wdata;
    logic [GPR_W-1:0]    w_load_val;

    assign w_access  = mem_re_i | mem_we_i;
    assign w_in_idle = (r_state == ST_IDLE);

    // The formatter sees the live instruction while idle, the captured one afterwards.
    assign w_fmt_mode    = w_in_idle ? mem_mode_i  : r_mode;
    assign w_fmt_addr_lo = w_in_idle ? addr_i[1:0] : r_addr[1:0];
    assign w_fmt_store   = w_in_idle ? mem_we_i    : r_we;

    dmem_lane_fmt u_lane_fmt (
        .i_mode     (w_fmt_mode),
        .i_addr_lo  (w_fmt_addr_lo),
        .i_is_store (w_fmt_store),
        .i_wdata    (wdata_i),
        .i_rdata    (dmem_rdata_i),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_legal    (w_legal),
        .o_load_val (w_load_val)
    );

    assign w_complete = ((r_state == ST_REQ) & dmem_gnt_i & dmem_rvalid_i) |
                        ((r_state == ST_WAIT) & dmem_rvalid_i);
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Stall is combinational in IDLE so the detecting instruction is held in the same cycle.
    assign stall_o = w_in_idle ? w_access : (r_state != ST_RESP);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_mode       <= '0;
            r_we         <= 1'b0;
            r_cnt        <= '0;
            done_o       <= 1'b0;
            exc_o        <= 1'b0;
            exc_cause_o  <= 2'b00;
            exc_addr_o   <= '0;
            load_val_o   <= '0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= 4'b0000;
            dmem_wdata_o <= '0;
        end else begin
            done_o <= 1'b0;
            exc_o  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        r_addr <= addr_i;
                        r_mode <= mem_mode_i;
                        r_we   <= mem_we_i;
                        if (w_legal) begin
                            r_state      <= ST_REQ;
                            r_cnt        <= '0;
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= mem_we_i;
                            dmem_addr_o  <= {addr_i[GPR_W-1:2], 2'b00};
                            dmem_be_o    <= w_be;
                            dmem_wdata_o <= w_wdata;
                        end else begin
                            r_state     <= ST_RESP;
                            done_o      <= 1'b1;
                            exc_o       <= 1'b1;
                            exc_cause_o <= mem_we_i ? EXC_STORE : EXC_LOAD;
                            exc_addr_o  <= addr_i;
                        end
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (w_complete) begin
                        r_state    <= ST_RESP;
                        dmem_req_o <= 1'b0;
                        done_o     <= 1'b1;
                        if (!r_we) begin
                            load_val_o <= w_load_val;
                        end
                    end else if (w_timeout) begin
                        r_state     <= ST_RESP;
                        dmem_req_o  <= 1'b0;
                        done_o      <= 1'b1;
                        exc_o       <= 1'b1;
                        exc_cause_o <= EXC_TIMEOUT;
                        exc_addr_o  <= r_addr;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if ((r_state == ST_REQ) && dmem_gnt_i) begin
                            r_state    <= ST_WAIT;
                            dmem_req_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    // RESP: the pipeline still presents the finished instruction, so inputs are ignored.
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
